simd_mac_acc: RTL and testbench
===============================

# simd_mac_acc

Pipelined, precision-configurable multiply-accumulate unit. It extends the fused 8x8 / 2x(4x4) / 4x(2x2) signed/unsigned multiplier to a generic DATA_W datapath. It adds per-lane accumulators, a valid/first/last framing protocol, and sticky per-lane overflow flags. It sits in the MAC slice between operand registers and the cascade/output stage.

## Interface
- DATA_W, 8: operand width. Power of two, 8 or more, divisible by 4.
- ACC_W, 4*DATA_W: accumulator width. Fixed relation, not to be overridden.
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset (fixed).
- in_valid  in  1  operand beat present.
- in_first  in  1  beat starts a new accumulation; samples mode/a_sign/b_sign.
- in_last  in  1  beat ends the accumulation; result emitted.
- mode  in  2  0: 1 lane full width, 1: 2 lanes of DATA_W/2, 2: 4 lanes of DATA_W/4, 3: reserved, treated as 0.
- a_sign, b_sign  in  1 each  operand A / B is two's complement.
- A, B  in  DATA_W each  packed operands; lane k = bits [(k+1)*LW-1 : k*LW], LW = DATA_W/lanes.
- out_valid  out  1  one-cycle pulse, final accumulation on out_acc.
- out_acc  out  ACC_W  packed lane accumulators; lane k field = [(k+1)*AW-1 : k*AW], AW = ACC_W/lanes.
- out_ovf  out  4  sticky overflow per lane; bit k valid for k < lanes, other bits 0.

## Operation
- Lane product: LW x LW, giving 2*LW bits. It is sign-extended to AW when a_sign|b_sign, otherwise zero-extended, then added into lane field k. No carry crosses a lane boundary.
- Accumulation arithmetic is modulo 2^AW per lane (wrap, no saturation).
- Overflow, signed (a_sign|b_sign): the two addends have equal sign and the sum sign differs. Unsigned: carry out of the lane MSB. The flag is sticky until the next in_first.
- mode, a_sign and b_sign are latched on the in_first beat. They are ignored on other beats. They are held in a config register that travels with the pipeline.
- A beat with in_first loads the accumulator with the product, not the sum, and clears out_ovf. This holds even if an accumulation is still open; the open accumulation is discarded with no out_valid.
- A beat with in_valid=0 changes no state; gaps between beats are allowed.
- Beats without in_first before any in_first since reset accumulate onto 0 with mode 0 unsigned.
- A beat with in_first and in_last together emits a single-product result.

## Timing
- Stage 0 (cycle t): beat accepted; operands and flags are registered.
- Stage 1 (t+1): lane products are registered.
- Stage 2 (t+2): accumulator is updated. For the in_last beat, out_valid=1 in the same cycle t+2, and out_acc/out_ovf show the final value including that beat.
- Throughput: one beat per cycle, no backpressure.
- out_acc holds its value between results. It shows the running sum, so only out_valid qualifies it.
- Reset values: out_valid=0, out_acc=0, out_ovf=0, config = mode 0 unsigned, all pipeline valids 0.
- Reset asserted mid-accumulation flushes in-flight beats. No out_valid is produced for them.

## Structure
- Package simd_mac_pkg holds:
  - the mode encodings MODE_FULL=0, MODE_HALF=1, MODE_QUARTER=2;
  - a function lanes(mode) returning 1/2/4;
  - the lane-width helpers.
- Sub-module simd_part_mult holds the combinational partitioned DATA_W x DATA_W multiplier. It uses a Baugh-Wooley style partial-product array with mode-gated cross-lane terms, and outputs 4 packed product fields.
- The top level holds the pipeline registers, config latch, lane-segmented adder, overflow logic and framing.

## Test plan
All scenarios use DATA_W=8.
- Mode 0 unsigned, single beat: A=0xFF, B=0xFF, first+last -> at t+2, out_valid=1, out_acc=0x0000FE01, out_ovf=0.
- Mode 0 signed, 3 beats of A=0x80, B=0x7F (first on beat 1, last on beat 3) -> out_acc=0xFFFF4180, exactly one out_valid pulse.
- Mode 1 unsigned, single beat: A=0xF3, B=0x2F -> out_acc=0x001E002D.
- Mode 2 signed, single beat: A=0xD9, B=0xFF -> out_acc=0x01FF02FF, out_ovf=0.
- Mode 2 unsigned, 29 back-to-back beats of A=0xFF, B=0xFF -> out_acc=0x05050505, out_ovf=4'hF. Flags stay 0 through beat 28 (running acc 0xFCFCFCFC).
- Framing and reset cases:
  - in_first beat A=0x02, B=0x03, then in_first+last beat A=0x04, B=0x05 -> single out_valid with out_acc=0x00000014.
  - reset asserted one cycle after a first+last beat -> no out_valid, out_acc=0.

Source files
------------

// File: rtl/simd_mac_acc_pkg.sv
// Shared types and helpers for the SIMD multiply-accumulate slice:
// lane-mode encodings, the per-beat config record and lane geometry functions.
package simd_mac_pkg;

    typedef enum logic [1:0] {
        MODE_FULL    = 2'd0,
        MODE_HALF    = 2'd1,
        MODE_QUARTER = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    typedef struct packed {
        mode_e mode;
        logic  aSign;
        logic  bSign;
    } cfg_t;

    localparam cfg_t CFG_RESET = '{mode: MODE_FULL, aSign: 1'b0, bSign: 1'b0};

    function automatic int unsigned lanes(input mode_e mode);
        case (mode)
            MODE_HALF:    return 2;
            MODE_QUARTER: return 4;
            default:      return 1;
        endcase
    endfunction

    function automatic int unsigned laneWidth(input int unsigned dataW, input mode_e mode);
        return dataW / lanes(mode);
    endfunction

    // The reserved encoding behaves exactly like a single full-width lane.
    function automatic mode_e normMode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_FULL : mode_e'(m);
    endfunction

endpackage

// File: rtl/simd_mac_acc_if.sv
// Beat/result bundle between the operand registers and the MAC slice.
interface simd_mac_acc_if #(
    parameter int DATA_W = 8
);
    logic                  in_valid;
    logic                  in_first;
    logic                  in_last;
    logic [1:0]            mode;
    logic                  a_sign;
    logic                  b_sign;
    logic [DATA_W-1:0]     A;
    logic [DATA_W-1:0]     B;
    logic                  out_valid;
    logic [4*DATA_W-1:0]   out_acc;
    logic [3:0]            out_ovf;

    modport master (
        output in_valid, in_first, in_last, mode, a_sign, b_sign, A, B,
        input  out_valid, out_acc, out_ovf
    );

    modport slave (
        input  in_valid, in_first, in_last, mode, a_sign, b_sign, A, B,
        output out_valid, out_acc, out_ovf
    );
endinterface

// File: rtl/simd_mac_acc_part_mult.sv
// Combinational partitioned multiplier: 1, 2 or 4 independent lanes packed into
// a 2*DATA_W product word, lane k occupying bits [k*2*LW +: 2*LW].
module simd_part_mult
    import simd_mac_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]   i_a,
    input  logic [DATA_W-1:0]   i_b,
    input  mode_e               i_mode,
    input  logic                i_aSign,
    input  logic                i_bSign,
    output logic [2*DATA_W-1:0] o_prod
);

    // Each partition only combines bits of its own lane; operands are extended
    // to the product width so the low 2*LW bits are the exact lane product.
    for (genvar g = 0; g < 3; g++) begin : g_part
        localparam int NL = int'(lanes(mode_e'(g)));
        localparam int LW = int'(laneWidth(DATA_W, mode_e'(g)));
        logic [2*DATA_W-1:0] w_prod;

        for (genvar k = 0; k < NL; k++) begin : g_lane
            logic            w_aSignBit;
            logic            w_bSignBit;
            logic [2*LW-1:0] w_aExt;
            logic [2*LW-1:0] w_bExt;

            assign w_aSignBit = i_aSign & i_a[(k+1)*LW-1];
            assign w_bSignBit = i_bSign & i_b[(k+1)*LW-1];
            assign w_aExt     = {{LW{w_aSignBit}}, i_a[k*LW +: LW]};
            assign w_bExt     = {{LW{w_bSignBit}}, i_b[k*LW +: LW]};
            assign w_prod[k*2*LW +: 2*LW] = w_aExt * w_bExt;
        end
    end

    always_comb begin
        o_prod = g_part[0].w_prod;
        case (i_mode)
            MODE_HALF:    o_prod = g_part[1].w_prod;
            MODE_QUARTER: o_prod = g_part[2].w_prod;
            default:      o_prod = g_part[0].w_prod;
        endcase
    end

endmodule

// File: rtl/simd_mac_acc.sv
// Three-stage SIMD multiply-accumulate: operand capture, lane products, then
// lane-segmented accumulation with sticky overflow and first/last framing.
module simd_mac_acc
    import simd_mac_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic           clk,
    input  logic           reset,
    simd_mac_acc_if.slave  bus
);

    localparam int ACC_W = 4 * DATA_W;

    logic                  r_s0Valid, r_s0First, r_s0Last;
    cfg_t                  r_s0Cfg;
    logic [DATA_W-1:0]     r_s0A, r_s0B;
    logic                  r_s1Valid, r_s1First, r_s1Last;
    cfg_t                  r_s1Cfg;
    logic [2*DATA_W-1:0]   r_s1Prod;
    logic [ACC_W-1:0]      r_acc;
    logic [3:0]            r_ovf;
    logic                  r_outValid;
    cfg_t                  w_beatCfg;
    logic [2*DATA_W-1:0]   w_prod;
    logic                  w_signedOp;
    logic [ACC_W-1:0]      w_nextAcc;
    logic [3:0]            w_newOvf;

    // The stage-0 config register doubles as the config latch: it only
    // changes on accepted beats and only picks up new settings on in_first.
    always_comb begin
        w_beatCfg = r_s0Cfg;
        if (bus.in_first) begin
            w_beatCfg = '{mode: normMode(bus.mode), aSign: bus.a_sign, bSign: bus.b_sign};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0Valid <= 1'b0;
            r_s0First <= 1'b0;
            r_s0Last  <= 1'b0;
            r_s0Cfg   <= CFG_RESET;
            r_s0A     <= '0;
            r_s0B     <= '0;
        end else begin
            r_s0Valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s0First <= bus.in_first;
                r_s0Last  <= bus.in_last;
                r_s0Cfg   <= w_beatCfg;
                r_s0A     <= bus.A;
                r_s0B     <= bus.B;
            end
        end
    end

    simd_part_mult #(.DATA_W(DATA_W)) u_mult (
        .i_a     (r_s0A),
        .i_b     (r_s0B),
        .i_mode  (r_s0Cfg.mode),
        .i_aSign (r_s0Cfg.aSign),
        .i_bSign (r_s0Cfg.bSign),
        .o_prod  (w_prod)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1Valid <= 1'b0;
            r_s1First <= 1'b0;
            r_s1Last  <= 1'b0;
            r_s1Cfg   <= CFG_RESET;
            r_s1Prod  <= '0;
        end else begin
            r_s1Valid <= r_s0Valid;
            if (r_s0Valid) begin
                r_s1First <= r_s0First;
                r_s1Last  <= r_s0Last;
                r_s1Cfg   <= r_s0Cfg;
                r_s1Prod  <= w_prod;
            end
        end
    end

    assign w_signedOp = r_s1Cfg.aSign | r_s1Cfg.bSign;

    // One adder bank per partition; carries never cross a lane boundary.
    for (genvar g = 0; g < 3; g++) begin : g_add
        localparam int NL = int'(lanes(mode_e'(g)));
        localparam int PW = 2 * DATA_W / NL;
        localparam int AW = ACC_W / NL;
        logic [ACC_W-1:0] w_sum;
        logic [3:0]       w_ovf;

        for (genvar k = 0; k < NL; k++) begin : g_lane
            logic          w_prodSign;
            logic [AW-1:0] w_prodExt;
            logic [AW-1:0] w_addend;
            logic [AW:0]   w_raw;

            assign w_prodSign = w_signedOp & r_s1Prod[k*PW + PW - 1];
            assign w_prodExt  = {{(AW-PW){w_prodSign}}, r_s1Prod[k*PW +: PW]};
            assign w_addend   = r_s1First ? '0 : r_acc[k*AW +: AW];
            assign w_raw      = {1'b0, w_addend} + {1'b0, w_prodExt};
            assign w_sum[k*AW +: AW] = w_raw[AW-1:0];
            assign w_ovf[k] = w_signedOp
                ? ((w_addend[AW-1] == w_prodExt[AW-1]) && (w_raw[AW-1] != w_addend[AW-1]))
                : w_raw[AW];
        end

        for (genvar k = NL; k < 4; k++) begin : g_unused
            assign w_ovf[k] = 1'b0;
        end
    end

    always_comb begin
        w_nextAcc = g_add[0].w_sum;
        w_newOvf  = g_add[0].w_ovf;
        case (r_s1Cfg.mode)
            MODE_HALF: begin
                w_nextAcc = g_add[1].w_sum;
                w_newOvf  = g_add[1].w_ovf;
            end
            MODE_QUARTER: begin
                w_nextAcc = g_add[2].w_sum;
                w_newOvf  = g_add[2].w_ovf;
            end
            default: begin
                w_nextAcc = g_add[0].w_sum;
                w_newOvf  = g_add[0].w_ovf;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc      <= '0;
            r_ovf      <= '0;
            r_outValid <= 1'b0;
        end else begin
            r_outValid <= r_s1Valid & r_s1Last;
            if (r_s1Valid) begin
                r_acc <= w_nextAcc;
                r_ovf <= r_s1First ? w_newOvf : (r_ovf | w_newOvf);
            end
        end
    end

    assign bus.out_valid = r_outValid;
    assign bus.out_acc   = r_acc;
    assign bus.out_ovf   = r_ovf;

endmodule

// File: tb/tb_simd_mac_acc.sv
// Self-checking bench for simd_mac_acc (DATA_W=8): directed scenarios plus
// randomized beats compared every cycle against a lane-arithmetic model.
module tb_simd_mac_acc;
    import simd_mac_pkg::*;

    localparam int DATA_W = 8;

    typedef struct packed {
        logic        valid;
        logic [31:0] acc;
        logic [3:0]  ovf;
    } obs_t;

    logic clk = 1'b0;
    logic reset;
    int   testsRun = 0;
    int   testsFailed = 0;

    int     mMode;
    bit     mAS, mBS;
    longint mLane [4];
    bit     mOvf [4];
    obs_t   dl [3];

    always #5 clk = ~clk;

    simd_mac_acc_if #(.DATA_W(DATA_W)) bus ();

    simd_mac_acc #(.DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic modelReset();
        mMode = 0;
        mAS   = 1'b0;
        mBS   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mLane[k] = 0;
            mOvf[k]  = 1'b0;
        end
    endtask

    // Lane values are plain integers; overflow is judged on the true sum.
    task automatic modelBeat(input bit first, input logic [1:0] mode, input bit as, input bit bs,
                             input logic [7:0] a, input logic [7:0] b);
        int     n, lw, aw;
        longint modv, half, av, bv, p, pm, base, sb;
        bit     ov;
        if (first) begin
            mMode = (mode == 2'd3) ? 0 : int'(mode);
            mAS   = as;
            mBS   = bs;
            for (int k = 0; k < 4; k++) begin
                mLane[k] = 0;
                mOvf[k]  = 1'b0;
            end
        end
        n    = 1 << mMode;
        lw   = 8 / n;
        aw   = 32 / n;
        modv = longint'(1) << aw;
        half = modv / 2;
        for (int k = 0; k < n; k++) begin
            av = (longint'(a) >> (k * lw)) & ((longint'(1) << lw) - 1);
            bv = (longint'(b) >> (k * lw)) & ((longint'(1) << lw) - 1);
            if (mAS && av >= (longint'(1) << (lw - 1))) av = av - (longint'(1) << lw);
            if (mBS && bv >= (longint'(1) << (lw - 1))) bv = bv - (longint'(1) << lw);
            p    = av * bv;
            base = mLane[k];
            if (mAS || mBS) begin
                sb = (base >= half) ? base - modv : base;
                ov = (sb + p >= half) || (sb + p < -half);
            end else begin
                ov = (base + p >= modv);
            end
            pm       = ((p % modv) + modv) % modv;
            mLane[k] = (base + pm) % modv;
            mOvf[k]  = mOvf[k] | ov;
        end
    endtask

    function automatic obs_t modelObs(input bit v);
        obs_t o;
        int   n, aw;
        n       = 1 << mMode;
        aw      = 32 / n;
        o.valid = v;
        o.acc   = '0;
        o.ovf   = '0;
        for (int k = 0; k < n; k++) begin
            o.acc  = o.acc | 32'(mLane[k] << (k * aw));
            o.ovf[k] = mOvf[k];
        end
        return o;
    endfunction

    // Drive one cycle, advance the model, and compare against the beat two edges back.
    task automatic applyStimulus(input bit rst, input bit vld, input bit first, input bit last,
                                 input logic [1:0] mode, input bit as, input bit bs,
                                 input logic [7:0] a, input logic [7:0] b);
        obs_t e;
        reset        = rst;
        bus.in_valid = vld;
        bus.in_first = first;
        bus.in_last  = last;
        bus.mode     = mode;
        bus.a_sign   = as;
        bus.b_sign   = bs;
        bus.A        = a;
        bus.B        = b;
        if (rst) begin
            modelReset();
            e     = modelObs(1'b0);
            dl[0] = e;
            dl[1] = e;
            dl[2] = e;
        end else begin
            if (vld) modelBeat(first, mode, as, bs, a, b);
            e     = modelObs(vld && last);
            dl[2] = dl[1];
            dl[1] = dl[0];
            dl[0] = e;
        end
        @(posedge clk);
        #1;
        checkOutput("outValid", 32'(bus.out_valid), 32'(dl[2].valid));
        checkOutput("outAcc",   bus.out_acc,        dl[2].acc);
        checkOutput("outOvf",   32'(bus.out_ovf),   32'(dl[2].ovf));
    endtask

    task automatic beat(input bit first, input bit last, input logic [1:0] mode,
                        input bit as, input bit bs, input logic [7:0] a, input logic [7:0] b);
        applyStimulus(1'b0, 1'b1, first, last, mode, as, bs, a, b);
    endtask

    task automatic idle();
        applyStimulus(1'b0, 1'b0, 1'($urandom), 1'($urandom), 2'($urandom), 1'($urandom),
                      1'($urandom), 8'($urandom), 8'($urandom));
    endtask

    function automatic logic [7:0] pickOperand();
        case ($urandom_range(0, 5))
            0:       return 8'hFF;
            1:       return 8'h80;
            2:       return 8'h7F;
            default: return 8'($urandom);
        endcase
    endfunction

    initial begin
        bus.in_valid = 1'b0;
        bus.in_first = 1'b0;
        bus.in_last  = 1'b0;
        bus.mode     = 2'd0;
        bus.a_sign   = 1'b0;
        bus.b_sign   = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        reset        = 1'b1;
        modelReset();
        for (int i = 0; i < 3; i++) dl[i] = '0;

        applyStimulus(1'b1, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'h00);
        applyStimulus(1'b1, 0, 0, 0, 2'd0, 0, 0, 8'h00, 8'h00);
        checkOutput("rstValid", 32'(bus.out_valid), 32'h0);
        checkOutput("rstAcc",   bus.out_acc,        32'h0);
        checkOutput("rstOvf",   32'(bus.out_ovf),   32'h0);

        beat(1, 1, 2'd0, 0, 0, 8'hFF, 8'hFF);
        idle();
        idle();
        checkOutput("fullUnsValid", 32'(bus.out_valid), 32'h1);
        checkOutput("fullUnsAcc",   bus.out_acc,        32'h0000FE01);
        checkOutput("fullUnsOvf",   32'(bus.out_ovf),   32'h0);

        beat(1, 0, 2'd0, 1, 1, 8'h80, 8'h7F);
        beat(0, 0, 2'd0, 1, 1, 8'h80, 8'h7F);
        beat(0, 1, 2'd0, 1, 1, 8'h80, 8'h7F);
        idle();
        idle();
        checkOutput("fullSgnValid", 32'(bus.out_valid), 32'h1);
        checkOutput("fullSgnAcc",   bus.out_acc,        32'hFFFF4180);

        beat(1, 1, 2'd1, 0, 0, 8'hF3, 8'h2F);
        idle();
        idle();
        checkOutput("halfUnsAcc", bus.out_acc, 32'h001E002D);

        beat(1, 1, 2'd2, 1, 1, 8'hD9, 8'hFF);
        idle();
        idle();
        checkOutput("quarSgnAcc", bus.out_acc,      32'h01FF02FF);
        checkOutput("quarSgnOvf", 32'(bus.out_ovf), 32'h0);

        for (int i = 1; i <= 29; i++) beat(i == 1, i == 29, 2'd2, 0, 0, 8'hFF, 8'hFF);
        idle();
        checkOutput("quarRun28Acc", bus.out_acc,      32'hFCFCFCFC);
        checkOutput("quarRun28Ovf", 32'(bus.out_ovf), 32'h0);
        idle();
        checkOutput("quarRun29Valid", 32'(bus.out_valid), 32'h1);
        checkOutput("quarRun29Acc",   bus.out_acc,        32'h05050505);
        checkOutput("quarRun29Ovf",   32'(bus.out_ovf),   32'hF);

        beat(1, 0, 2'd0, 0, 0, 8'h02, 8'h03);
        beat(1, 1, 2'd0, 0, 0, 8'h04, 8'h05);
        idle();
        checkOutput("reopenNoValid", 32'(bus.out_valid), 32'h0);
        idle();
        checkOutput("reopenValid", 32'(bus.out_valid), 32'h1);
        checkOutput("reopenAcc",   bus.out_acc,        32'h00000014);

        beat(1, 1, 2'd0, 0, 0, 8'h11, 8'h22);
        applyStimulus(1'b1, 1, 1, 1, 2'd0, 0, 0, 8'h33, 8'h44);
        idle();
        checkOutput("flushValid", 32'(bus.out_valid), 32'h0);
        checkOutput("flushAcc",   bus.out_acc,        32'h0);
        idle();
        checkOutput("flushLateValid", 32'(bus.out_valid), 32'h0);

        for (int phase = 0; phase < 2; phase++) begin
            int firstPct;
            firstPct = (phase == 0) ? 25 : 3;
            for (int i = 0; i < 500; i++) begin
                applyStimulus($urandom_range(0, 99) < 1,
                              $urandom_range(0, 99) < 75,
                              $urandom_range(0, 99) < firstPct,
                              $urandom_range(0, 99) < 15,
                              2'($urandom), 1'($urandom), 1'($urandom),
                              pickOperand(), pickOperand());
            end
        end
        idle();
        idle();
        idle();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
